// File: rtl/bk_add_arbiter.sv
// -----------------------------------------------------------------------------
// bk_add_arbiter
//   Shares one 16-bit Brent-Kung adder (BKadder) among NREQ requesters.
//   A round-robin arbiter grants one pending requester. The block registers
//   that requester's operands and gives the adder one full cycle to settle.
//   It then presents the registered sum, carry-out and requester index on a
//   valid/ready response port.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   req_valid  : [NREQ]     requester i has an operand pair pending
//   req_a      : [NREQ*16]  operand A, requester i in bits [16i+15:16i]
//   req_b      : [NREQ*16]  operand B, same packing
//   req_ready  : [NREQ]     one-hot/zero, requester i accepted this cycle
//   rsp_valid  : response holds a completed result
//   rsp_ready  : consumer takes the response this cycle
//   rsp_id     : [IDW]      owner of the response
//   rsp_sum    : [16]       (a+b) mod 2^16
//   rsp_cout   : carry-out of a+b
// -----------------------------------------------------------------------------
module bk_add_arbiter #(
    parameter int  NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q,     state_d;
    logic [IDW-1:0]  last_q,      last_d;
    logic [15:0]     op_a_q,      op_a_d;
    logic [15:0]     op_b_q,      op_b_d;
    logic [IDW-1:0]  op_id_q,     op_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [15:0]     rsp_sum_q,   rsp_sum_d;
    logic            rsp_cout_q,  rsp_cout_d;

    logic            grant_hit_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [15:0]     sel_a_s;
    logic [15:0]     sel_b_s;
    logic [NREQ-1:0] req_ready_s;
    logic [15:0]     add_sum_s;
    logic            add_cout_s;

    // The single shared adder always sees the operand registers.
    BKadder u_bkadder (
        .a    (op_a_q),
        .b    (op_b_q),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Round-robin candidate search: the scan runs from farthest to nearest
    // (last+NREQ down to last+1), so the nearest valid requester after last
    // overwrites any earlier pick.
    always_comb begin
        grant_hit_s = 1'b0;
        grant_idx_s = '0;
        sel_a_s     = 16'h0000;
        sel_b_s     = 16'h0000;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_q) + k) % NREQ;
            if (req_valid[idx]) begin
                grant_hit_s = 1'b1;
                grant_idx_s = IDW'(idx);
                sel_a_s     = req_a[idx*16 +: 16];
                sel_b_s     = req_b[idx*16 +: 16];
            end else begin
                // requester idx idle: keep the nearer candidate already chosen
            end
        end
    end

    // Next-state, grant and register-load decisions of the sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        req_ready_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_hit_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    op_a_d  = sel_a_s;
                    op_b_d  = sel_b_s;
                    op_id_d = grant_idx_s;
                    last_d  = grant_idx_s;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                // adder has had a full cycle on stable operands
                rsp_sum_d   = add_sum_s;
                rsp_cout_d  = add_cout_s;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (grant_hit_s) begin
                        // consume and accept back-to-back in the same cycle
                        req_ready_s[grant_idx_s] = 1'b1;
                        op_a_d  = sel_a_s;
                        op_b_d  = sel_b_s;
                        op_id_d = grant_idx_s;
                        last_d  = grant_idx_s;
                        state_d = ST_ADD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer, operand and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= IDW'(NREQ - 1);
            op_a_q      <= 16'h0000;
            op_b_q      <= 16'h0000;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= 16'h0000;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// -----------------------------------------------------------------------------
// BKadder
//   16-bit unsigned Brent-Kung parallel-prefix adder, no carry-in.
//   a, b : operands; sum : (a+b) mod 2^16; cout : bit 16 of a+b.
// -----------------------------------------------------------------------------
module BKadder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] gl_s;
    logic [15:0] pl_s;
    logic [15:0] hx_s;

    // Prefix tree. The up-sweep builds group (G,P) over spans 2, 4, 8 and 16
    // at odd positions. The down-sweep then fills in the remaining prefixes,
    // so gl_s[i] ends up as the carry out of bits [i:0].
    always_comb begin
        hx_s = a ^ b;
        gl_s = a & b;
        pl_s = a ^ b;
        for (int k = 0; k < 8; k++) begin
            gl_s[2*k+1] = gl_s[2*k+1] | (pl_s[2*k+1] & gl_s[2*k]);
            pl_s[2*k+1] = pl_s[2*k+1] & pl_s[2*k];
        end
        for (int k = 0; k < 4; k++) begin
            gl_s[4*k+3] = gl_s[4*k+3] | (pl_s[4*k+3] & gl_s[4*k+1]);
            pl_s[4*k+3] = pl_s[4*k+3] & pl_s[4*k+1];
        end
        for (int k = 0; k < 2; k++) begin
            gl_s[8*k+7] = gl_s[8*k+7] | (pl_s[8*k+7] & gl_s[8*k+3]);
            pl_s[8*k+7] = pl_s[8*k+7] & pl_s[8*k+3];
        end
        gl_s[15] = gl_s[15] | (pl_s[15] & gl_s[7]);
        pl_s[15] = pl_s[15] & pl_s[7];
        // down-sweep
        gl_s[11] = gl_s[11] | (pl_s[11] & gl_s[7]);
        for (int k = 0; k < 3; k++) begin
            gl_s[4*k+5] = gl_s[4*k+5] | (pl_s[4*k+5] & gl_s[4*k+3]);
        end
        for (int k = 0; k < 7; k++) begin
            gl_s[2*k+2] = gl_s[2*k+2] | (pl_s[2*k+2] & gl_s[2*k+1]);
        end
    end

    assign sum  = hx_s ^ {gl_s[14:0], 1'b0};
    assign cout = gl_s[15];

endmodule
